vc_input_unit: RTL and testbench

Parametrised successor to the per-port input stage of the router: a single input port with a configurable VC count and per-VC buffer depth.
- Per-VC FSM (IDLE/VA/ACTIVE) with registered XY route computation.
- Credit-return output replaces on/off backpressure; sticky error flags.
- Instantiated PORT_NUM times by the router's input block; talks to the VC allocator, switch allocator and crossbar.

---
 rtl/noc_params.sv | 66 ++++++
 rtl/vc_fifo.sv | 94 +++++++++
 rtl/vc_input_unit.sv | 171 +++++++++++++++++
 tb/tb_vc_input_unit.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Shared NoC types for the input stage: flit format, VC ids, VC states, output ports
// and the XY routing helper used when a head flit reaches the front of a VC.
package noc_params;

    localparam int MESH_SIZE_X      = 4;
    localparam int MESH_SIZE_Y      = 4;
    localparam int VC_NUM           = 4;
    localparam int VC_SIZE          = $clog2(VC_NUM);
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
    localparam int PAYLOAD_SIZE     = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef logic [VC_SIZE-1:0] vc_id_t;

    typedef logic [1:0] vc_state_t;
    localparam vc_state_t IDLE   = 2'd0;
    localparam vc_state_t VA     = 2'd1;
    localparam vc_state_t ACTIVE = 2'd2;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

    typedef struct packed {
        flit_label_t                 label;
        vc_id_t                      vc_id;
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [PAYLOAD_SIZE-1:0]     payload;
    } flit_t;

    // X is resolved before Y, so a packet only turns once.
    function automatic port_t route_xy(
        input logic [DEST_ADDR_SIZE_X-1:0] x_dest,
        input logic [DEST_ADDR_SIZE_Y-1:0] y_dest,
        input int                          x_cur,
        input int                          y_cur
    );
        int x_d;
        int y_d;
        x_d = int'(x_dest);
        y_d = int'(y_dest);
        if (x_d > x_cur)
            return EAST;
        else if (x_d < x_cur)
            return WEST;
        else if (y_d > y_cur)
            return SOUTH;
        else if (y_d < y_cur)
            return NORTH;
        else
            return LOCAL;
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC flit FIFO with arbitrary depth. With VC_OCCUPANCY_EN defined, full/empty come
// from a registered flit count exported on o_count; otherwise from pointers plus wrap bits.
module vc_fifo
    import noc_params::*;
#(
    parameter int BUFFER_DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_wr_en,
    input  flit_t i_data,
    input  logic  i_rd_en,
    output flit_t o_data,
    output logic  o_empty,
    output logic  o_full
`ifdef VC_OCCUPANCY_EN
    ,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0] o_count
`endif
);

    localparam int PTR_W = $clog2(BUFFER_DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BUFFER_DEPTH - 1);

    flit_t            r_mem [BUFFER_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_push;
    logic             w_pop;
    logic             w_wr_last;
    logic             w_rd_last;

    // A write to a full FIFO is dropped even when a pop happens in the same cycle.
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;
    assign w_wr_last = (r_wr_ptr == LAST_IDX);
    assign w_rd_last = (r_rd_ptr == LAST_IDX);
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + 1'b1;
        end
    end

`ifdef VC_OCCUPANCY_EN
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
        else if (!w_push && w_pop)
            r_count <= r_count - 1'b1;
    end

    assign o_full  = (r_count == CNT_W'(BUFFER_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
`else
    logic r_wr_wrap;
    logic r_rd_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_wrap <= 1'b0;
            r_rd_wrap <= 1'b0;
        end else begin
            if (w_push && w_wr_last)
                r_wr_wrap <= ~r_wr_wrap;
            if (w_pop && w_rd_last)
                r_rd_wrap <= ~r_rd_wrap;
        end
    end

    assign o_full  = (r_wr_ptr == r_rd_ptr) && (r_wr_wrap != r_rd_wrap);
    assign o_empty = (r_wr_ptr == r_rd_ptr) && (r_wr_wrap == r_rd_wrap);
`endif

endmodule

// File: rtl/vc_input_unit.sv
// Router input port: per-VC FIFOs and FSMs, XY route, VA/SA handshakes, credit return.
// Optional VC_OCCUPANCY_EN adds occupancy_o with the registered per-VC flit count.
//
//   state  | meaning
//   IDLE   | waiting for a head flit at the FIFO front; stray body/tail flits are dropped
//   VA     | route latched, requesting a downstream VC
//   ACTIVE | downstream VC held, requesting the switch while flits are buffered
module vc_input_unit
    import noc_params::*;
#(
    parameter int VC_CNT       = VC_NUM,
    parameter int BUFFER_DEPTH = 8,
    parameter int X_CURRENT    = MESH_SIZE_X / 2,
    parameter int Y_CURRENT    = MESH_SIZE_Y / 2
) (
    input  logic              clk,
    input  logic              rst,
    input  flit_t             data_i,
    input  logic              valid_flit_i,
    output logic [VC_CNT-1:0] va_request_o,
    output port_t             out_port_o [VC_CNT],
    input  logic [VC_CNT-1:0] va_valid_i,
    input  vc_id_t            va_new_vc_i [VC_CNT],
    output logic [VC_CNT-1:0] sa_request_o,
    output vc_id_t            sa_downstream_vc_o [VC_CNT],
    input  logic              sa_valid_i,
    input  vc_id_t            sa_sel_vc_i,
    output flit_t             xb_flit_o,
    output logic              xb_valid_o,
    output logic              credit_valid_o,
    output vc_id_t            credit_vc_o,
    output logic [VC_CNT-1:0] vc_allocatable_o,
    output logic [2:0]        error_o
`ifdef VC_OCCUPANCY_EN
    ,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0] occupancy_o [VC_CNT]
`endif
);

    flit_t             w_front [VC_CNT];
    logic [VC_CNT-1:0] w_empty;
    logic [VC_CNT-1:0] w_full;
    logic [VC_CNT-1:0] w_wr_req;
    logic [VC_CNT-1:0] w_rd_en;
    logic [VC_CNT-1:0] w_pop_sa;
    logic [VC_CNT-1:0] w_pop_idle;
    logic [VC_CNT-1:0] w_front_head;
    logic [VC_CNT-1:0] w_front_tail;
    logic              w_sa_ok;
    logic              w_in_head;
    flit_t             w_xb_next;

    logic              r_xb_valid;
    flit_t             r_xb_flit;
    logic              r_credit_valid;
    vc_id_t            r_credit_vc;
    logic [2:0]        r_error;

    assign w_in_head = (data_i.label == HEAD) || (data_i.label == HEADTAIL);

    for (genvar v = 0; v < VC_CNT; v++) begin : g_vc
        vc_state_t r_state;
        port_t     r_out_port;
        vc_id_t    r_ds_vc;
        logic      r_allocatable;

        assign w_wr_req[v]     = valid_flit_i && (data_i.vc_id == vc_id_t'(v));
        assign w_front_head[v] = (w_front[v].label == HEAD) || (w_front[v].label == HEADTAIL);
        assign w_front_tail[v] = (w_front[v].label == TAIL) || (w_front[v].label == HEADTAIL);
        assign w_pop_sa[v]     = sa_valid_i && (sa_sel_vc_i == vc_id_t'(v))
                               && (r_state == ACTIVE) && !w_empty[v];
        assign w_pop_idle[v]   = (r_state == IDLE) && !w_empty[v] && !w_front_head[v];
        assign w_rd_en[v]      = w_pop_sa[v] || w_pop_idle[v];

        assign va_request_o[v]       = (r_state == VA);
        assign sa_request_o[v]       = (r_state == ACTIVE) && !w_empty[v];
        assign out_port_o[v]         = r_out_port;
        assign sa_downstream_vc_o[v] = r_ds_vc;
        assign vc_allocatable_o[v]   = r_allocatable;

        vc_fifo #(
            .BUFFER_DEPTH(BUFFER_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_wr_en (w_wr_req[v]),
            .i_data  (data_i),
            .i_rd_en (w_rd_en[v]),
            .o_data  (w_front[v]),
            .o_empty (w_empty[v]),
            .o_full  (w_full[v])
`ifdef VC_OCCUPANCY_EN
            ,
            .o_count (occupancy_o[v])
`endif
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state       <= IDLE;
                r_out_port    <= LOCAL;
                r_ds_vc       <= '0;
                r_allocatable <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!w_empty[v] && w_front_head[v]) begin
                            r_out_port <= route_xy(w_front[v].x_dest, w_front[v].y_dest,
                                                   X_CURRENT, Y_CURRENT);
                            r_state    <= VA;
                        end
                    end
                    VA: begin
                        if (va_valid_i[v]) begin
                            r_ds_vc <= va_new_vc_i[v];
                            r_state <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (w_pop_sa[v] && w_front_tail[v])
                            r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase

                // A new head claiming the VC wins over a tail releasing it in the same cycle.
                if (w_wr_req[v] && !w_full[v] && w_in_head)
                    r_allocatable <= 1'b0;
                else if (w_pop_sa[v] && w_front_tail[v])
                    r_allocatable <= 1'b1;
            end
        end
    end

    assign w_sa_ok = |w_pop_sa;

    always_comb begin
        w_xb_next = '0;
        for (int v = 0; v < VC_CNT; v++) begin
            if (w_pop_sa[v]) begin
                w_xb_next       = w_front[v];
                w_xb_next.vc_id = sa_downstream_vc_o[v];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xb_valid     <= 1'b0;
            r_xb_flit      <= '0;
            r_credit_valid <= 1'b0;
            r_credit_vc    <= '0;
            r_error        <= '0;
        end else begin
            r_xb_valid     <= w_sa_ok;
            r_credit_valid <= w_sa_ok;
            if (w_sa_ok) begin
                r_xb_flit   <= w_xb_next;
                r_credit_vc <= sa_sel_vc_i;
            end
            r_error <= r_error | {(|w_pop_idle), (sa_valid_i && !w_sa_ok), (|(w_wr_req & w_full))};
        end
    end

    assign xb_valid_o     = r_xb_valid;
    assign xb_flit_o      = r_xb_flit;
    assign credit_valid_o = r_credit_valid;
    assign credit_vc_o    = r_credit_vc;
    assign error_o        = r_error;

endmodule

// File: tb/tb_vc_input_unit.sv
// Scenario bench for vc_input_unit (depth-3 FIFOs); crossbar outputs are checked against
// a queue of expected flits filled whenever a switch grant is driven.
module tb_vc_input_unit;
    import noc_params::*;

    localparam int VC_CNT = 4;
    localparam int DEPTH  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    flit_t             data_i = '0;
    logic              valid_flit_i = 1'b0;
    logic [VC_CNT-1:0] va_request_o;
    port_t             out_port_o [VC_CNT];
    logic [VC_CNT-1:0] va_valid_i = '0;
    vc_id_t            va_new_vc_i [VC_CNT];
    logic [VC_CNT-1:0] sa_request_o;
    vc_id_t            sa_downstream_vc_o [VC_CNT];
    logic              sa_valid_i = 1'b0;
    vc_id_t            sa_sel_vc_i = '0;
    flit_t             xb_flit_o;
    logic              xb_valid_o;
    logic              credit_valid_o;
    vc_id_t            credit_vc_o;
    logic [VC_CNT-1:0] vc_allocatable_o;
    logic [2:0]        error_o;
`ifdef VC_OCCUPANCY_EN
    logic [$clog2(DEPTH+1)-1:0] occupancy_o [VC_CNT];
`endif

    typedef struct {
        flit_t  flit;
        vc_id_t cvc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    vc_input_unit #(
        .VC_CNT(VC_CNT),
        .BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .data_i             (data_i),
        .valid_flit_i       (valid_flit_i),
        .va_request_o       (va_request_o),
        .out_port_o         (out_port_o),
        .va_valid_i         (va_valid_i),
        .va_new_vc_i        (va_new_vc_i),
        .sa_request_o       (sa_request_o),
        .sa_downstream_vc_o (sa_downstream_vc_o),
        .sa_valid_i         (sa_valid_i),
        .sa_sel_vc_i        (sa_sel_vc_i),
        .xb_flit_o          (xb_flit_o),
        .xb_valid_o         (xb_valid_o),
        .credit_valid_o     (credit_valid_o),
        .credit_vc_o        (credit_vc_o),
        .vc_allocatable_o   (vc_allocatable_o),
        .error_o            (error_o)
`ifdef VC_OCCUPANCY_EN
        ,
        .occupancy_o        (occupancy_o)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && xb_valid_o === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL xb_unexpected: got flit %h credit_vc %0d, expected no output",
                         xb_flit_o, credit_vc_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (xb_flit_o !== e.flit || credit_valid_o !== 1'b1 || credit_vc_o !== e.cvc) begin
                    n_errors++;
                    $display("FAIL xb_output: got flit %h credit %b/%0d, expected flit %h credit 1/%0d",
                             xb_flit_o, credit_valid_o, credit_vc_o, e.flit, e.cvc);
                end
            end
        end else if (!rst && credit_valid_o === 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL credit_without_flit: got credit_valid 1 vc %0d, expected 0", credit_vc_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic flit_t mk(flit_label_t l, int vc, int x, int y, int pay);
        flit_t f;
        f.label   = l;
        f.vc_id   = vc[VC_SIZE-1:0];
        f.x_dest  = x[DEST_ADDR_SIZE_X-1:0];
        f.y_dest  = y[DEST_ADDR_SIZE_Y-1:0];
        f.payload = pay[PAYLOAD_SIZE-1:0];
        return f;
    endfunction

    function automatic exp_t mk_exp(flit_t f, int ds, int cvc);
        exp_t e;
        e.flit       = f;
        e.flit.vc_id = ds[VC_SIZE-1:0];
        e.cvc        = cvc[VC_SIZE-1:0];
        return e;
    endfunction

    task automatic apply_reset();
        rst          = 1'b1;
        valid_flit_i = 1'b0;
        va_valid_i   = '0;
        sa_valid_i   = 1'b0;
        tick();
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({va_request_o, sa_request_o, xb_valid_o, credit_valid_o, error_o, vc_allocatable_o}
            !== {4'b0, 4'b0, 1'b0, 1'b0, 3'b0, 4'hF}) begin
            n_errors++;
            $display("FAIL reset_ctrl: got va %b sa %b xb %b cr %b err %b alloc %b, expected 0 0 0 0 000 1111",
                     va_request_o, sa_request_o, xb_valid_o, credit_valid_o, error_o, vc_allocatable_o);
        end
        for (int v = 0; v < VC_CNT; v++) begin
            n_checks++;
            if (out_port_o[v] !== LOCAL || sa_downstream_vc_o[v] !== '0) begin
                n_errors++;
                $display("FAIL reset_vc%0d: got port %0d ds %0d, expected 0 0", v,
                         out_port_o[v], sa_downstream_vc_o[v]);
            end
        end
        n_checks++;
        if (xb_flit_o !== '0 || credit_vc_o !== '0) begin
            n_errors++;
            $display("FAIL reset_data: got flit %h credit_vc %0d, expected 0 0", xb_flit_o, credit_vc_o);
        end
    endtask

    task automatic test_single_headtail();
        flit_t f;
        apply_reset();
        f = mk(HEADTAIL, 0, 3, 2, 16'hA5A5);
        data_i = f;
        valid_flit_i = 1'b1;
        tick();
        valid_flit_i = 1'b0;
        tick();
        n_checks++;
        if (va_request_o !== 4'b0001 || out_port_o[0] !== EAST) begin
            n_errors++;
            $display("FAIL single_va: got va %b port %0d, expected 0001 %0d", va_request_o, out_port_o[0], EAST);
        end
        va_valid_i = 4'b0001;
        va_new_vc_i[0] = vc_id_t'(2);
        tick();
        va_valid_i = '0;
        n_checks++;
        if (sa_request_o !== 4'b0001 || sa_downstream_vc_o[0] !== vc_id_t'(2) || vc_allocatable_o !== 4'b1110) begin
            n_errors++;
            $display("FAIL single_active: got sa %b ds %0d alloc %b, expected 0001 2 1110",
                     sa_request_o, sa_downstream_vc_o[0], vc_allocatable_o);
        end
        sa_valid_i  = 1'b1;
        sa_sel_vc_i = vc_id_t'(0);
        exp_q.push_back(mk_exp(f, 2, 0));
        tick();
        sa_valid_i = 1'b0;
        n_checks++;
        if (xb_valid_o !== 1'b1 || vc_allocatable_o !== 4'hF || va_request_o !== 4'b0 || sa_request_o !== 4'b0) begin
            n_errors++;
            $display("FAIL single_done: got xb %b alloc %b va %b sa %b, expected 1 1111 0000 0000",
                     xb_valid_o, vc_allocatable_o, va_request_o, sa_request_o);
        end
        for (int k = 0; k < 16 && exp_q.size() != 0; k++) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL single_drain: got %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_packet_stream();
        flit_t pkt [4];
        apply_reset();
        pkt[0] = mk(HEAD, 1, 2, 0, 16'h1000);
        pkt[1] = mk(BODY, 1, 2, 0, 16'h1001);
        pkt[2] = mk(BODY, 1, 2, 0, 16'h1002);
        pkt[3] = mk(TAIL, 1, 2, 0, 16'h1003);
        data_i = pkt[0];
        valid_flit_i = 1'b1;
        tick();
        valid_flit_i = 1'b0;
        tick();
        n_checks++;
        if (va_request_o !== 4'b0010 || out_port_o[1] !== NORTH) begin
            n_errors++;
            $display("FAIL stream_va: got va %b port %0d, expected 0010 %0d", va_request_o, out_port_o[1], NORTH);
        end
        va_valid_i = 4'b0010;
        va_new_vc_i[1] = vc_id_t'(3);
        tick();
        va_valid_i = '0;
        for (int i = 0; i < 4; i++) begin
            sa_valid_i  = 1'b1;
            sa_sel_vc_i = vc_id_t'(1);
            if (i < 3) begin
                data_i = pkt[i+1];
                valid_flit_i = 1'b1;
            end else begin
                valid_flit_i = 1'b0;
            end
            exp_q.push_back(mk_exp(pkt[i], 3, 1));
            tick();
            n_checks++;
            if (xb_valid_o !== 1'b1) begin
                n_errors++;
                $display("FAIL stream_pulse%0d: got xb_valid %b, expected 1", i, xb_valid_o);
            end
        end
        sa_valid_i   = 1'b0;
        valid_flit_i = 1'b0;
        n_checks++;
        if (va_request_o !== 4'b0 || sa_request_o !== 4'b0 || vc_allocatable_o !== 4'hF || error_o !== 3'b000) begin
            n_errors++;
            $display("FAIL stream_idle: got va %b sa %b alloc %b err %b, expected 0000 0000 1111 000",
                     va_request_o, sa_request_o, vc_allocatable_o, error_o);
        end
        for (int k = 0; k < 16 && exp_q.size() != 0; k++) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL stream_drain: got %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        flit_t pkt [4];
        apply_reset();
        pkt[0] = mk(HEAD, 0, 2, 2, 16'h2000);
        pkt[1] = mk(BODY, 0, 2, 2, 16'h2001);
        pkt[2] = mk(BODY, 0, 2, 2, 16'h2002);
        pkt[3] = mk(BODY, 0, 2, 2, 16'h2003);
        for (int i = 0; i < 4; i++) begin
            data_i = pkt[i];
            valid_flit_i = 1'b1;
            tick();
        end
        valid_flit_i = 1'b0;
        n_checks++;
        if (error_o !== 3'b001 || va_request_o !== 4'b0001 || out_port_o[0] !== LOCAL) begin
            n_errors++;
            $display("FAIL overflow_flag: got err %b va %b port %0d, expected 001 0001 0",
                     error_o, va_request_o, out_port_o[0]);
        end
`ifdef VC_OCCUPANCY_EN
        n_checks++;
        if (occupancy_o[0] !== 2'd3) begin
            n_errors++;
            $display("FAIL overflow_occupancy: got %0d, expected 3", occupancy_o[0]);
        end
`endif
        va_valid_i = 4'b0001;
        va_new_vc_i[0] = vc_id_t'(1);
        tick();
        va_valid_i = '0;
        for (int i = 0; i < 3; i++) begin
            sa_valid_i  = 1'b1;
            sa_sel_vc_i = vc_id_t'(0);
            exp_q.push_back(mk_exp(pkt[i], 1, 0));
            tick();
        end
        sa_valid_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0 || sa_request_o !== 4'b0 || vc_allocatable_o[0] !== 1'b0 || error_o !== 3'b001) begin
            n_errors++;
            $display("FAIL overflow_drain: got left %0d sa %b alloc0 %b err %b, expected 0 0000 0 001",
                     exp_q.size(), sa_request_o, vc_allocatable_o[0], error_o);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        sa_valid_i  = 1'b1;
        sa_sel_vc_i = vc_id_t'(2);
        tick();
        sa_valid_i = 1'b0;
        n_checks++;
        if (xb_valid_o !== 1'b0 || credit_valid_o !== 1'b0 || error_o !== 3'b010) begin
            n_errors++;
            $display("FAIL underflow: got xb %b credit %b err %b, expected 0 0 010",
                     xb_valid_o, credit_valid_o, error_o);
        end
        tick();
    endtask

    task automatic test_protocol();
        apply_reset();
        data_i = mk(BODY, 3, 1, 1, 16'h3003);
        valid_flit_i = 1'b1;
        tick();
        valid_flit_i = 1'b0;
        tick();
        n_checks++;
        if (error_o !== 3'b100 || credit_valid_o !== 1'b0 || vc_allocatable_o !== 4'hF || va_request_o !== 4'b0) begin
            n_errors++;
            $display("FAIL protocol: got err %b credit %b alloc %b va %b, expected 100 0 1111 0000",
                     error_o, credit_valid_o, vc_allocatable_o, va_request_o);
        end
        tick();
        n_checks++;
        if (credit_valid_o !== 1'b0 || sa_request_o !== 4'b0) begin
            n_errors++;
            $display("FAIL protocol_late: got credit %b sa %b, expected 0 0000", credit_valid_o, sa_request_o);
        end
`ifdef VC_OCCUPANCY_EN
        n_checks++;
        if (occupancy_o[3] !== 2'd0) begin
            n_errors++;
            $display("FAIL protocol_occupancy: got %0d, expected 0", occupancy_o[3]);
        end
`endif
    endtask

    task automatic test_reset_midpacket();
        flit_t h;
        flit_t f;
        apply_reset();
        h = mk(HEAD, 0, 3, 3, 16'h4000);
        data_i = h;
        valid_flit_i = 1'b1;
        tick();
        data_i = mk(BODY, 0, 3, 3, 16'h4001);
        tick();
        valid_flit_i = 1'b0;
        va_valid_i = 4'b0001;
        va_new_vc_i[0] = vc_id_t'(2);
        tick();
        va_valid_i = '0;
        sa_valid_i  = 1'b1;
        sa_sel_vc_i = vc_id_t'(0);
        exp_q.push_back(mk_exp(h, 2, 0));
        tick();
        sa_valid_i = 1'b0;
        tick();
        n_checks++;
        if (sa_request_o !== 4'b0001 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL midpkt_before: got sa %b left %0d, expected 0001 0", sa_request_o, exp_q.size());
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({va_request_o, sa_request_o, xb_valid_o, credit_valid_o, error_o, vc_allocatable_o}
            !== {4'b0, 4'b0, 1'b0, 1'b0, 3'b0, 4'hF}
            || out_port_o[0] !== LOCAL || sa_downstream_vc_o[0] !== '0
            || xb_flit_o !== '0 || credit_vc_o !== '0) begin
            n_errors++;
            $display("FAIL midpkt_reset: got va %b sa %b xb %b cr %b err %b alloc %b port %0d ds %0d flit %h cvc %0d, expected all 0 and alloc 1111",
                     va_request_o, sa_request_o, xb_valid_o, credit_valid_o, error_o, vc_allocatable_o,
                     out_port_o[0], sa_downstream_vc_o[0], xb_flit_o, credit_vc_o);
        end
        f = mk(HEADTAIL, 0, 1, 2, 16'h4444);
        data_i = f;
        valid_flit_i = 1'b1;
        tick();
        valid_flit_i = 1'b0;
        tick();
        n_checks++;
        if (va_request_o !== 4'b0001 || out_port_o[0] !== WEST) begin
            n_errors++;
            $display("FAIL midpkt_fresh_va: got va %b port %0d, expected 0001 %0d", va_request_o, out_port_o[0], WEST);
        end
        va_valid_i = 4'b0001;
        va_new_vc_i[0] = vc_id_t'(1);
        tick();
        va_valid_i = '0;
        sa_valid_i  = 1'b1;
        sa_sel_vc_i = vc_id_t'(0);
        exp_q.push_back(mk_exp(f, 1, 0));
        tick();
        sa_valid_i = 1'b0;
        for (int k = 0; k < 16 && exp_q.size() != 0; k++) tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0 || error_o !== 3'b000 || vc_allocatable_o !== 4'hF) begin
            n_errors++;
            $display("FAIL midpkt_fresh_done: got left %0d err %b alloc %b, expected 0 000 1111",
                     exp_q.size(), error_o, vc_allocatable_o);
        end
    endtask

    initial begin
        for (int v = 0; v < VC_CNT; v++) va_new_vc_i[v] = '0;
        test_reset();
        test_single_headtail();
        test_packet_stream();
        test_overflow();
        test_underflow();
        test_protocol();
        test_reset_midpacket();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
